// File: rtl/montprod_mem.sv
// montprod_mem: operand (A, B, M) and result (R) storage for the montprod engine.
// Four 256x32 banks, one-cycle registered engine and host reads, and a small
// sequencer that zero-fills the low words of R before each calculation.
module montprod_mem (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        cs,
    input  logic        we,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        host_error,

    input  logic        lock,
    input  logic [7:0]  length,
    input  logic        clear,
    output logic        ready,

    input  logic [7:0]  opa_addr,
    output logic [31:0] opa_data,
    input  logic [7:0]  opb_addr,
    output logic [31:0] opb_data,
    input  logic [7:0]  opm_addr,
    output logic [31:0] opm_data,

    input  logic [7:0]  result_addr,
    input  logic [31:0] result_data,
    input  logic        result_we
);

    typedef enum logic {StIdle, StClear} state_e;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] mem_m [256];
    logic [31:0] mem_r [256];

    state_e      state_q;
    logic [7:0]  ctr_q;
    logic [7:0]  len_q;

    logic [1:0]  bank;
    logic [7:0]  word;
    logic        host_wr;
    logic        host_rd;
    logic        clearing;
    logic        host_reject;
    logic        host_wr_ok;
    logic        clear_wr;
    logic [31:0] host_rd_word;

    assign bank        = address[9:8];
    assign word        = address[7:0];
    assign host_wr     = cs & we;
    assign host_rd     = cs & ~we;
    assign clearing    = (state_q == StClear);
    // R-bank writes from the host would collide with the engine or the sequencer.
    assign host_reject = lock | clearing | ((bank == 2'd3) & result_we);
    assign host_wr_ok  = host_wr & ~host_reject;
    // The engine always wins R; the sequencer steps aside and retries next cycle.
    assign clear_wr    = clearing & ~result_we;

    // Host read mux, old data on read-during-write.
    always_comb begin
        host_rd_word = '0;
        unique case (bank)
            2'd0: host_rd_word = mem_a[word];
            2'd1: host_rd_word = mem_b[word];
            2'd2: host_rd_word = mem_m[word];
            2'd3: host_rd_word = mem_r[word];
        endcase
    end

    // Bank writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (host_wr_ok && bank == 2'd0) mem_a[word] <= write_data;
        if (host_wr_ok && bank == 2'd1) mem_b[word] <= write_data;
        if (host_wr_ok && bank == 2'd2) mem_m[word] <= write_data;
        if (result_we) begin
            mem_r[result_addr] <= result_data;
        end else if (clear_wr) begin
            mem_r[ctr_q] <= '0;
        end else if (host_wr_ok && bank == 2'd3) begin
            mem_r[word] <= write_data;
        end
    end

    // Registered engine/host read ports and the rejected-write pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_data   <= '0;
            opb_data   <= '0;
            opm_data   <= '0;
            read_data  <= '0;
            host_error <= 1'b0;
        end else begin
            opa_data   <= mem_a[opa_addr];
            opb_data   <= mem_b[opb_addr];
            opm_data   <= mem_m[opm_addr];
            if (host_rd) begin
                read_data <= host_rd_word;
            end
            host_error <= host_wr & host_reject;
        end
    end

    // Clear sequencer: zero R[0..length-1], holding ctr on engine collisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ctr_q   <= '0;
            len_q   <= '0;
            ready   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clear && length != 8'd0) begin
                        state_q <= StClear;
                        ctr_q   <= '0;
                        len_q   <= length;
                        ready   <= 1'b0;
                    end
                end
                StClear: begin
                    if (clear_wr) begin
                        if (ctr_q == len_q - 8'd1) begin
                            state_q <= StIdle;
                            ctr_q   <= '0;
                            ready   <= 1'b1;
                        end else begin
                            ctr_q <= ctr_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
